// File: rtl/cla_adder_4_if.sv
// rtl/cla_adder_4_if.sv - operand/result bundle for the 4-bit carry-lookahead slice
interface cla_adder_4_if;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [3:0] sum;
   logic       cout;
   logic       gen;
   logic       prop;

   modport master (output a, b, cin, input sum, cout, gen, prop);
   modport slave  (input a, b, cin, output sum, cout, gen, prop);
endinterface

// File: rtl/cla_adder_4.sv
// rtl/cla_adder_4.sv - 4-bit carry-lookahead adder slice with group generate/propagate
// REG_OUT=1 registers every output once; REG_OUT=0 leaves the slice purely combinational.
module cla_adder_4 #(
   parameter bit REG_OUT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   cla_adder_4_if.slave  cla
);
   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;
   logic [3:0] w_sum;
   logic       w_gen;
   logic       w_prop;

   assign w_g = cla.a & cla.b;
   assign w_p = cla.a ^ cla.b;

   // Every carry is a flat sum of products so no carry depends on another carry.
   assign w_c[0] = cla.cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cla.cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cla.cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cla.cin);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cla.cin);

   assign w_sum  = w_p ^ w_c[3:0];
   assign w_gen  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign w_prop = &w_p;

   generate
      if (REG_OUT) begin : g_reg
         logic [3:0] r_sum;
         logic       r_cout;
         logic       r_gen;
         logic       r_prop;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sum  <= 4'h0;
               r_cout <= 1'b0;
               r_gen  <= 1'b0;
               r_prop <= 1'b0;
            end else begin
               r_sum  <= w_sum;
               r_cout <= w_c[4];
               r_gen  <= w_gen;
               r_prop <= w_prop;
            end
         end

         assign cla.sum  = r_sum;
         assign cla.cout = r_cout;
         assign cla.gen  = r_gen;
         assign cla.prop = r_prop;
      end else begin : g_comb
         assign cla.sum  = w_sum;
         assign cla.cout = w_c[4];
         assign cla.gen  = w_gen;
         assign cla.prop = w_prop;
      end
   endgenerate
endmodule

// File: tb/tb_cla_adder_4.sv
// tb/tb_cla_adder_4.sv - directed and exhaustive checks for cla_adder_4 with REG_OUT=1
module tb_cla_adder_4;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   cla_adder_4_if bus ();

   cla_adder_4 #(.REG_OUT(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .cla (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      logic [6:0] obs;
      rst = 1'b1;
      bus.a = 4'hF; bus.b = 4'hF; bus.cin = 1'b1;
      #2;
      obs = {bus.cout, bus.sum, bus.gen, bus.prop};
      n_tests++;
      if (obs !== 7'h00) begin
         n_fail++;
         $display("FAIL reset_async: got %h expected %h", obs, 7'h00);
      end
      repeat (3) @(posedge clk);
      #1;
      obs = {bus.cout, bus.sum, bus.gen, bus.prop};
      n_tests++;
      if (obs !== 7'h00) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected %h", obs, 7'h00);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      obs = {bus.cout, bus.sum, bus.gen, bus.prop};
      n_tests++;
      // F+F+1 = 31: cout=1 sum=F gen=1 prop=0
      if (obs !== {1'b1, 4'hF, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected %h", obs, {1'b1, 4'hF, 1'b1, 1'b0});
      end
   endtask

   task automatic test_directed();
      logic [3:0] ta [6];
      logic [3:0] tb [6];
      logic       tc [6];
      logic [6:0] te [6];
      logic [6:0] obs;
      ta = '{4'hF, 4'h5, 4'h5, 4'h0, 4'h8, 4'hF};
      tb = '{4'h1, 4'hA, 4'hA, 4'h0, 4'h8, 4'h0};
      tc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      // {cout, sum, gen, prop}
      te = '{{1'b1, 4'h0, 1'b1, 1'b0},
             {1'b0, 4'hF, 1'b0, 1'b1},
             {1'b1, 4'h0, 1'b0, 1'b1},
             {1'b0, 4'h1, 1'b0, 1'b0},
             {1'b1, 4'h0, 1'b1, 1'b0},
             {1'b1, 4'h0, 1'b0, 1'b1}};
      for (int i = 0; i < 6; i++) begin
         bus.a = ta[i]; bus.b = tb[i]; bus.cin = tc[i];
         @(posedge clk);
         #1;
         obs = {bus.cout, bus.sum, bus.gen, bus.prop};
         n_tests++;
         if (obs !== te[i]) begin
            n_fail++;
            $display("FAIL directed_%0d: a=%h b=%h cin=%b got %h expected %h",
                     i, ta[i], tb[i], tc[i], obs, te[i]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [8:0] v;
      logic [4:0] exp_total;
      logic       exp_gen;
      logic       exp_prop;
      for (int i = 0; i < 512; i++) begin
         v = i[8:0];
         bus.a = v[8:5]; bus.b = v[4:1]; bus.cin = v[0];
         exp_total = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'h0, v[0]};
         exp_gen   = ({1'b0, v[8:5]} + {1'b0, v[4:1]}) > 5'd15;
         exp_prop  = &(v[8:5] ^ v[4:1]);
         @(posedge clk);
         #1;
         n_tests++;
         if ({bus.cout, bus.sum} !== exp_total) begin
            n_fail++;
            $display("FAIL sweep_sum: a=%h b=%h cin=%b got %h expected %h",
                     v[8:5], v[4:1], v[0], {bus.cout, bus.sum}, exp_total);
         end
         n_tests++;
         if (bus.cout !== (bus.gen | (bus.prop & v[0]))) begin
            n_fail++;
            $display("FAIL sweep_group: a=%h b=%h cin=%b cout %b gen %b prop %b",
                     v[8:5], v[4:1], v[0], bus.cout, bus.gen, bus.prop);
         end
         n_tests++;
         if ({bus.gen, bus.prop} !== {exp_gen, exp_prop}) begin
            n_fail++;
            $display("FAIL sweep_genprop: a=%h b=%h got %b%b expected %b%b",
                     v[8:5], v[4:1], bus.gen, bus.prop, exp_gen, exp_prop);
         end
         if (i == 300) begin
            #2;
            rst = 1'b1;
            #1;
            n_tests++;
            if ({bus.cout, bus.sum, bus.gen, bus.prop} !== 7'h00) begin
               n_fail++;
               $display("FAIL midstream_reset: got %h expected %h",
                        {bus.cout, bus.sum, bus.gen, bus.prop}, 7'h00);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if ({bus.cout, bus.sum, bus.gen, bus.prop} !== 7'h00) begin
               n_fail++;
               $display("FAIL midstream_reset_hold: got %h expected %h",
                        {bus.cout, bus.sum, bus.gen, bus.prop}, 7'h00);
            end
            rst = 1'b0;
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.a = 4'h0; bus.b = 4'h0; bus.cin = 1'b0;
      test_reset();
      test_directed();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
